// File: rtl/imem_arbiter_pkg.sv
// Shared widths, in-flight owner encodings and the owner-selection helper
// for the instruction-memory arbiter.
package imem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_F    = 2'd1;
    localparam logic [1:0] OWN_L    = 2'd2;

    // Writes leave the memory output untouched, so they never own a return slot.
    function automatic logic [1:0] read_owner(input logic f_gnt,
                                              input logic l_gnt,
                                              input logic l_we);
        if (l_gnt && !l_we) begin
            return OWN_L;
        end else if (f_gnt) begin
            return OWN_F;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Counts consecutive denied loader cycles and raises l_prio once the loader
// has waited MAX_WAIT cycles, so it wins the next arbitration.
module imem_starve_ctr
    import imem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic l_req,
    input  logic l_gnt,
    output logic l_prio
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!l_req || l_gnt) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != MAX_CNT) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    assign l_prio = (wait_cnt_reg == MAX_CNT);

endmodule

// File: rtl/imem_arbiter.sv
// Fixed-priority (fetch first) arbiter for the single-port instruction memory,
// with loader starvation guard and a sticky check of the echoed read address.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [WORD_W-1:0] f_rdata,
    output logic [ADDR_W-1:0] f_raddr,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [WORD_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [WORD_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] m_A,
    output logic              m_W,
    output logic [WORD_W-1:0] m_D,
    input  logic [WORD_W-1:0] m_Q,
    input  logic [ADDR_W-1:0] m_Ao,
    output logic              err
);

    logic              l_prio;
    logic [1:0]        owner_reg;
    logic [1:0]        owner_next;
    logic [ADDR_W-1:0] exp_addr_reg;
    logic [ADDR_W-1:0] exp_addr_next;
    logic              err_reg;
    logic              err_next;

    imem_starve_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .l_req  (l_req),
        .l_gnt  (l_gnt),
        .l_prio (l_prio)
    );

    // Loader wins when starved or when fetch is idle; fetch takes everything else.
    assign l_gnt = l_req & (l_prio | ~f_req);
    assign f_gnt = f_req & ~l_gnt;

    always_comb begin
        m_A = f_addr;
        m_W = 1'b0;
        m_D = '0;
        if (l_gnt) begin
            m_A = l_addr;
            m_W = l_we;
            m_D = l_wdata;
        end
    end

    always_comb begin
        owner_next    = read_owner(f_gnt, l_gnt, l_we);
        exp_addr_next = exp_addr_reg;
        if (owner_next != OWN_NONE) begin
            exp_addr_next = m_A;
        end
        err_next = err_reg | ((owner_reg != OWN_NONE) && (m_Ao != exp_addr_reg));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg    <= OWN_NONE;
            exp_addr_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            owner_reg    <= owner_next;
            exp_addr_reg <= exp_addr_next;
            err_reg      <= err_next;
        end
    end

    assign f_rvalid = (owner_reg == OWN_F);
    assign l_rvalid = (owner_reg == OWN_L);
    assign f_rdata  = m_Q;
    assign l_rdata  = m_Q;
    assign f_raddr  = m_Ao;
    assign err      = err_reg;

endmodule
